fetch_stage: RTL and testbench

Instruction fetch stage plus IF/ID pipeline register, sitting directly upstream of the decode-stage controller.
- Holds the PC and issues one word fetch at a time over an SRAM-like instruction port (req/addr_ok/data_ok).
- Delivers instrD/pcD/validD to decode.
- Honours decode stalls, branch/jump redirects (delay slot preserved) and exception redirects (all in-flight work discarded).

---
 rtl/fetch_stage_pkg.sv | 14 +
 rtl/fetch_stage_if_id.sv | 18 +
 rtl/fetch_stage.sv | 125 ++++++++++++
 tb/tb_fetch_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared constants, fetch FSM states and IF/ID payload layout
package fetch_stage_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fs_state_e;
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;
endpackage

// File: rtl/fetch_stage_if_id.sv
// if_id_reg: IF/ID pipeline register {validD, pcD, instrD} with load enable and sync clear
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  en_i,
  input  logic  clr_i,
  input  ifid_t d_i,
  output ifid_t q_o
);
  ifid_t q_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) q_q <= '0;
    else if (en_i) q_q <= d_i;
  end
  assign q_o = q_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: single-outstanding instruction fetch with redirect/exception handling feeding IF/ID
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallD,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        validD
);
  fs_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d, pend_pc_q, pend_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d, hold_pc_q, hold_pc_d;
  logic        pend_valid_q, pend_valid_d, discard_q, discard_d;
  logic        load, clr, redir;
  ifid_t       ifid_d, ifid_q;
  assign redir     = redirect_valid && !stallD;
  assign inst_req  = !rst && state_q == FS_REQ;
  assign inst_addr = {pc_q[31:2], 2'b00};
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    discard_d    = discard_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    load         = 1'b0;
    ifid_d       = '{valid: 1'b1,
                     pc:    state_q == FS_HOLD ? hold_pc_q : req_pc_q,
                     instr: state_q == FS_HOLD ? hold_instr_q : inst_rdata};
    case (state_q)
      FS_REQ: begin
        if (inst_addr_ok) begin
          req_pc_d     = pc_q;
          pc_d         = redir ? redirect_pc : pend_valid_q ? pend_pc_q : pc_q + 32'd4;
          pend_valid_d = 1'b0;
          state_d      = FS_WAIT;
        end else if (redir) begin
          // delay slot not yet issued: remember the target until it is
          pend_valid_d = 1'b1;
          pend_pc_d    = redirect_pc;
        end
      end
      FS_WAIT: begin
        if (redir) pc_d = redirect_pc;
        if (inst_data_ok) begin
          if (discard_q) begin
            discard_d = 1'b0;
            state_d   = FS_REQ;
          end else if (!stallD) begin
            load    = 1'b1;
            state_d = FS_REQ;
          end else begin
            hold_instr_d = inst_rdata;
            hold_pc_d    = req_pc_q;
            state_d      = FS_HOLD;
          end
        end
      end
      FS_HOLD: begin
        if (redir) pc_d = redirect_pc;
        if (!stallD) begin
          load    = 1'b1;
          state_d = FS_REQ;
        end
      end
      default: state_d = FS_REQ;
    endcase
    if (exc_valid) begin
      // anything accepted but not yet returned must be swallowed when it arrives
      pc_d         = exc_pc;
      pend_valid_d = 1'b0;
      load         = 1'b0;
      discard_d    = (state_q == FS_REQ && inst_addr_ok) || (state_q == FS_WAIT && !inst_data_ok);
      state_d      = discard_d ? FS_WAIT : FS_REQ;
    end
  end
  assign clr = exc_valid || (!stallD && !load);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FS_REQ;
      pc_q         <= RESET_PC;
      req_pc_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      discard_q    <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      discard_q    <= discard_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end
  if_id_reg u_if_id (
    .clk  (clk),
    .rst  (rst),
    .en_i (load),
    .clr_i(clr),
    .d_i  (ifid_d),
    .q_o  (ifid_q)
  );
  assign validD = ifid_q.valid;
  assign pcD    = ifid_q.pc;
  assign instrD = ifid_q.instr;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboarded bench with a behavioural instruction memory
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, stallD, redirect_valid, exc_valid, inst_addr_ok, inst_data_ok;
  logic [31:0] redirect_pc, exc_pc, inst_rdata;
  logic        inst_req, validD;
  logic [31:0] inst_addr, instrD, pcD;
  int          tests = 0, fails = 0;
  logic [31:0] exp_iss[$], exp_pc[$], exp_in[$];
  bit          allow_addr = 1'b0, pending = 1'b0, obs_req;
  int          data_delay = 1, wait_cnt = 0;
  logic [31:0] paddr = '0;
  localparam logic [31:0] BASE = 32'hBFC0_0000;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .stallD(stallD),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_valid(exc_valid), .exc_pc(exc_pc),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .instrD(instrD), .pcD(pcD), .validD(validD)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return ((a - BASE) >> 2) + 32'd1;
  endfunction

  task automatic push(input logic [31:0] a, input bit deliver);
    exp_iss.push_back(a);
    if (deliver) begin
      exp_pc.push_back(a);
      exp_in.push_back(mem(a));
    end
  endtask

  // one clock: memory responds, DUT edge, then scoreboard the result
  task automatic cycle();
    bit acc, dv, stall_e;
    logic [31:0] acc_addr, e;
    inst_data_ok = pending && wait_cnt == 0;
    inst_rdata   = inst_data_ok ? mem(paddr) : 32'hDEAD_BEEF;
    inst_addr_ok = inst_req && allow_addr && !pending;
    @(negedge clk);
    acc = inst_addr_ok; acc_addr = inst_addr; dv = inst_data_ok;
    stall_e = stallD; obs_req = inst_req;
    @(posedge clk); #1;
    if (dv) pending = 1'b0;
    else if (pending && wait_cnt > 0) wait_cnt--;
    if (acc) begin
      pending = 1'b1; wait_cnt = data_delay - 1; paddr = acc_addr;
      tests++;
      if (exp_iss.size() == 0) begin
        fails++; $display("FAIL issue: unexpected fetch addr %h", acc_addr);
      end else begin
        e = exp_iss.pop_front();
        if (acc_addr !== e) begin fails++; $display("FAIL issue: addr %h expected %h", acc_addr, e); end
      end
    end
    if (!stall_e && validD) begin
      tests++;
      if (exp_pc.size() == 0) begin
        fails++; $display("FAIL deliver: unexpected pcD %h instrD %h", pcD, instrD);
      end else begin
        e = exp_pc.pop_front();
        if (pcD !== e) begin fails++; $display("FAIL deliver_pc: pcD %h expected %h", pcD, e); end
        e = exp_in.pop_front();
        tests++;
        if (instrD !== e) begin fails++; $display("FAIL deliver_instr: instrD %h expected %h", instrD, e); end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin fails++; $display("FAIL %s: got %h expected %h", name, got, want); end
  endtask

  task automatic chk_drained(input string name);
    tests++;
    if (exp_iss.size() != 0 || exp_pc.size() != 0) begin
      fails++; $display("FAIL %s: %0d issues and %0d deliveries outstanding, expected 0", name, exp_iss.size(), exp_pc.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    tests++;
    if (obs_req !== 1'b0) begin fails++; $display("FAIL reset_req: inst_req %b expected 0", obs_req); end
    cycle();
    rst = 1'b0;
    tests++;
    if (validD !== 1'b0) begin fails++; $display("FAIL reset_valid: validD %b expected 0", validD); end
    tests++;
    if (instrD !== 32'h0) begin fails++; $display("FAIL reset_instr: instrD %h expected 0", instrD); end
    tests++;
    if (pcD !== 32'h0) begin fails++; $display("FAIL reset_pc: pcD %h expected 0", pcD); end
    tests++;
    if (inst_addr !== BASE) begin fails++; $display("FAIL reset_addr: inst_addr %h expected %h", inst_addr, BASE); end
    #1;
    tests++;
    if (inst_req !== 1'b1) begin fails++; $display("FAIL reset_req_after: inst_req %b expected 1", inst_req); end
  endtask

  task automatic test_back_to_back();
    bit ev;
    for (int i = 0; i < 4; i++) push(BASE + 32'(4 * i), 1'b1);
    allow_addr = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      ev = (i % 2) == 1;
      tests++;
      if (validD !== ev) begin fails++; $display("FAIL b2b_valid: cycle %0d validD %b expected %b", i, validD, ev); end
    end
    allow_addr = 1'b0;
    chk_drained("b2b_drain");
  endtask

  task automatic test_stall();
    push(BASE + 32'h10, 1'b1);
    allow_addr = 1'b1;
    cycle();
    stallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      tests++;
      if (obs_req !== 1'b0) begin fails++; $display("FAIL stall_req: cycle %0d inst_req %b expected 0", i, obs_req); end
      tests++;
      if (validD !== 1'b0) begin fails++; $display("FAIL stall_valid: cycle %0d validD %b expected 0", i, validD); end
    end
    allow_addr = 1'b0;
    stallD = 1'b0;
    cycle();
    chk_drained("stall_release");
    chk("stall_next_addr", inst_addr, BASE + 32'h14);
  endtask

  task automatic test_branch_req();
    redirect_valid = 1'b1; redirect_pc = BASE + 32'h100;
    cycle();
    redirect_valid = 1'b0;
    chk("br_req_addr_hold", inst_addr, BASE + 32'h14);
    push(BASE + 32'h14, 1'b1);
    push(BASE + 32'h100, 1'b1);
    allow_addr = 1'b1;
    repeat (4) cycle();
    allow_addr = 1'b0;
    chk_drained("br_req_drain");
  endtask

  task automatic test_branch_wait();
    stallD = 1'b1; data_delay = 3; allow_addr = 1'b1;
    exp_iss.push_back(BASE + 32'h104);
    cycle();
    chk("br_wait_hold_pcD", pcD, BASE + 32'h100);
    allow_addr = 1'b0; stallD = 1'b0;
    redirect_valid = 1'b1; redirect_pc = BASE + 32'h200;
    cycle();
    redirect_valid = 1'b0;
    exp_pc.push_back(BASE + 32'h104); exp_in.push_back(mem(BASE + 32'h104));
    repeat (2) cycle();
    chk_drained("br_wait_slot");
    chk("br_wait_next_addr", inst_addr, BASE + 32'h200);
    data_delay = 1; allow_addr = 1'b1;
    push(BASE + 32'h200, 1'b1);
    repeat (2) cycle();
    allow_addr = 1'b0;
    chk_drained("br_wait_target");
  endtask

  task automatic test_exception();
    data_delay = 3; allow_addr = 1'b1;
    exp_iss.push_back(BASE + 32'h204);
    cycle();
    allow_addr = 1'b0;
    exc_valid = 1'b1; exc_pc = BASE + 32'h380;
    cycle();
    exc_valid = 1'b0;
    chk("exc_valid_clr", {31'b0, validD}, 32'h0);
    chk("exc_instr_clr", instrD, 32'h0);
    repeat (2) cycle();
    chk("exc_after_valid", {31'b0, validD}, 32'h0);
    chk("exc_addr", inst_addr, BASE + 32'h380);
    chk("exc_req", {31'b0, inst_req}, 32'h1);
    data_delay = 1; allow_addr = 1'b1;
    push(BASE + 32'h380, 1'b1);
    repeat (2) cycle();
    allow_addr = 1'b0;
    chk_drained("exc_handler");
  endtask

  task automatic test_exc_redirect();
    exc_valid = 1'b1; exc_pc = BASE + 32'h500;
    redirect_valid = 1'b1; redirect_pc = BASE + 32'h600;
    cycle();
    exc_valid = 1'b0; redirect_valid = 1'b0;
    chk("exc_redir_addr", inst_addr, BASE + 32'h500);
    push(BASE + 32'h500, 1'b1);
    push(BASE + 32'h504, 1'b1);
    allow_addr = 1'b1;
    repeat (4) cycle();
    allow_addr = 1'b0;
    chk_drained("exc_redir_drain");
  endtask

  initial begin
    rst = 1'b1; stallD = 1'b0; redirect_valid = 1'b0; exc_valid = 1'b0;
    redirect_pc = '0; exc_pc = '0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_back_to_back();
    test_stall();
    test_branch_req();
    test_branch_wait();
    test_exception();
    test_exc_redirect();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
